sdram_read_ctrl: RTL and testbench
==================================

// Module: sdram_read_ctrl
// PURPOSE
// Parametrised SDRAM full-page read engine; successor to the fixed 16-bit read FSM. Converts one
// request (linear address + beat count) into ACTIVE/READ/BURST_TERM/PRECHARGE sequences.
// Bursts crossing a page (column wrap) split automatically into per-row segments. Sits under the
// SDRAM arbiter beside the write/refresh engines; drives the shared cmd/addr bus via the arbiter mux.
// PARAMETERS
// DW       16  data width
// BA_W     2   bank address width
// ROW_W    13  row address width (>=11)
// COL_W    9   column address width (<=10)
// LEN_W    10  beat-count width; max request 2**LEN_W-1 beats
// CAS_LAT  3   CAS latency in clk cycles (2 or 3)
// T_RCD    2   ACTIVE->READ wait cycles
// T_RP     2   PRECHARGE->next command wait cycles
// PORTS
// clk            in   1                 clock
// rst_n          in   1                 asynchronous, active-low reset
// rd_en          in   1                 request strobe; accepted only when rd_busy=0
// rd_addr        in   BA_W+ROW_W+COL_W  start address {bank,row,col}
// rd_burst_len   in   LEN_W             beats to read
// rd_sdram_data  in   DW                SDRAM DQ input
// rd_busy        out  1                 request in progress
// rd_cmd         out  4                 {CS,RAS,CAS,WE}: NOP=1000 ACT=0011 RD=0101 BT=0110 PRE=0010
// rd_bank_addr   out  BA_W              SDRAM BA
// rd_sdram_addr  out  ROW_W             SDRAM A
// rd_ack         out  1                 rd_data valid this cycle
// rd_data        out  DW                read beat; 0 when rd_ack=0
// rd_end         out  1                 one-cycle pulse: request complete
// BEHAVIOUR
// - Reset: state IDLE, rd_cmd=NOP, rd_bank_addr all-1, rd_sdram_addr all-1, rd_ack/rd_end/rd_busy=0,
//   rd_data=0. Reset mid-operation aborts at once; no completion pulse.
// - Accept: rd_en && state==IDLE latches addr/len; rd_busy=1 from next cycle through RD_END inclusive.
//   rd_en while busy ignored. rd_burst_len==0: IDLE->RD_END, no SDRAM commands.
// - States: IDLE->ACTIVE->WAIT_TRCD(T_RCD)->READ->WAIT_CAS->BURST->PRE_CHARG->WAIT_TRP(T_RP)
//   ->(remaining>0 ? ACTIVE : RD_END)->IDLE. All outputs registered from state.
// - Segment length seg = min(remaining, 2**COL_W - col). Next segment: col=0, row+1; row overflow
//   carries into bank; top address wraps to 0.
// - Addr bus: ACT -> row; RD -> {zeros, col}, A10=0 (no auto-precharge); PRE -> all-1 except A10=0
//   (single bank); else all-1. Bank = segment bank for ACT/RD/PRE, else all-1.
// - Timing, R = cycle rd_cmd==RD: BT at R+seg (also when seg=2**COL_W); DQ beats on R+CL..R+CL+seg-1;
//   rd_ack=1 on R+CL+1..R+CL+seg (one input register stage), contiguous per segment; PRE at R+CL+seg.
//   READ issued no earlier than T_RCD+1 cycles after ACT; next ACT/IDLE no earlier than T_RP+1 after PRE.
// - Total rd_ack beats per request = rd_burst_len exactly, in address order; gap between segments.
// - rd_end: single pulse in RD_END after last segment's WAIT_TRP; never per segment.
// - Internal counters LEN_W+3 bits; no overflow for any legal seg/CAS_LAT.
// TESTING
// T1 CL3, addr {1,5,0}, len 4 -> ACT(b1,r5), RD(col0) 3 cycles later, BT at R+4, rd_ack R+4..R+7, data=model, one rd_end.
// T2 col 510, len 4 (COL_W=9) -> two ACT/RD/PRE groups: r cols 510-511, r+1 cols 0-1; 4 beats total; one rd_end.
// T3 col 0, len 512 -> single segment, 512 contiguous beats, BT at R+512; row 8191 col 511 len 2 -> 2nd seg bank+1 row 0.
// T4 len 0 -> no non-NOP command, rd_end one cycle after accept; rd_en during busy -> ignored, no extra beats.
// T5 CAS_LAT=2 instance, len 3 -> rd_ack R+3..R+5, PRE at R+5.
// T6 rst_n low mid-BURST -> next edge rd_cmd=NOP, rd_ack=0, rd_busy=0; following request completes normally.

Source files
------------

// File: rtl/sdram_read_ctrl.sv
// SDRAM full-page read engine: turns one {bank,row,col} + beat-count request into
// ACTIVE/READ/BURST_TERM/PRECHARGE groups, splitting bursts at page boundaries.
module sdram_read_ctrl #(
   parameter int unsigned DW      = 16,
   parameter int unsigned BA_W    = 2,
   parameter int unsigned ROW_W   = 13,
   parameter int unsigned COL_W   = 9,
   parameter int unsigned LEN_W   = 10,
   parameter int unsigned CAS_LAT = 3,
   parameter int unsigned T_RCD   = 2,
   parameter int unsigned T_RP    = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rd_en,
   input  logic [BA_W+ROW_W+COL_W-1:0]   rd_addr,
   input  logic [LEN_W-1:0]              rd_burst_len,
   input  logic [DW-1:0]                 rd_sdram_data,
   output logic                          rd_busy,
   output logic [3:0]                    rd_cmd,
   output logic [BA_W-1:0]               rd_bank_addr,
   output logic [ROW_W-1:0]              rd_sdram_addr,
   output logic                          rd_ack,
   output logic [DW-1:0]                 rd_data,
   output logic                          rd_end
);

   localparam int unsigned CNT_W = LEN_W + 3;
   localparam int unsigned PAGE  = 1 << COL_W;

   localparam logic [3:0] CMD_NOP = 4'b1000;
   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_RD  = 4'b0101;
   localparam logic [3:0] CMD_BT  = 4'b0110;
   localparam logic [3:0] CMD_PRE = 4'b0010;

   // A10 low on PRECHARGE selects the single addressed bank
   localparam logic [ROW_W-1:0] ADDR_PRE = ~(ROW_W'(1) << 10);

   typedef enum logic [3:0] {
      IDLE, ACTIVE, WAIT_TRCD, READ, WAIT_CAS, BURST, PRE_CHARG, WAIT_TRP, RD_END
   } state_e;

   state_e              state_q, state_d;
   logic [BA_W-1:0]     seg_ba_q, seg_ba_d;
   logic [ROW_W-1:0]    seg_row_q, seg_row_d;
   logic [COL_W-1:0]    seg_col_q, seg_col_d;
   logic [CNT_W-1:0]    rem_q, rem_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [3:0]          cmd_q, cmd_d;
   logic [BA_W-1:0]     bank_q, bank_d;
   logic [ROW_W-1:0]    addr_q, addr_d;
   logic                busy_q, busy_d;
   logic                ack_q, ack_d;
   logic [DW-1:0]       data_q, data_d;
   logic                end_q, end_d;

   logic [CNT_W-1:0]    room_c, seg_c, last_c;

   // Beats in the current segment are capped by what is left of the page
   always_comb begin
      room_c = CNT_W'(PAGE) - CNT_W'(seg_col_q);
      seg_c  = (rem_q < room_c) ? rem_q : room_c;
      last_c = CNT_W'(CAS_LAT) + seg_c - CNT_W'(1);
   end

   // cnt_q is zero on the READ cycle and counts up through the burst
   always_comb begin
      state_d   = state_q;
      seg_ba_d  = seg_ba_q;
      seg_row_d = seg_row_q;
      seg_col_d = seg_col_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (rd_en) begin
               {seg_ba_d, seg_row_d, seg_col_d} = rd_addr;
               rem_d   = CNT_W'(rd_burst_len);
               cnt_d   = '0;
               state_d = (rd_burst_len == '0) ? RD_END : ACTIVE;
            end
         end
         ACTIVE: begin
            cnt_d   = CNT_W'(1);
            state_d = WAIT_TRCD;
         end
         WAIT_TRCD: begin
            if (cnt_q >= CNT_W'(T_RCD)) begin
               cnt_d   = '0;
               state_d = READ;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         READ: begin
            cnt_d   = CNT_W'(1);
            state_d = WAIT_CAS;
         end
         WAIT_CAS: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(CAS_LAT - 1)) state_d = BURST;
         end
         BURST: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == last_c) state_d = PRE_CHARG;
         end
         PRE_CHARG: begin
            cnt_d     = CNT_W'(1);
            state_d   = WAIT_TRP;
            rem_d     = rem_q - seg_c;
            seg_col_d = '0;
            {seg_ba_d, seg_row_d} = {seg_ba_q, seg_row_q} + (BA_W + ROW_W)'(1);
         end
         WAIT_TRP: begin
            if (cnt_q >= CNT_W'(T_RP)) begin
               cnt_d   = '0;
               state_d = (rem_q != '0) ? ACTIVE : RD_END;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RD_END:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Command bus decoded from the next state so it lines up with state_q
      cmd_d  = CMD_NOP;
      bank_d = '1;
      addr_d = '1;
      case (state_d)
         ACTIVE: begin
            cmd_d  = CMD_ACT;
            bank_d = seg_ba_d;
            addr_d = seg_row_d;
         end
         READ: begin
            cmd_d  = CMD_RD;
            bank_d = seg_ba_d;
            addr_d = ROW_W'(seg_col_d);
         end
         PRE_CHARG: begin
            cmd_d  = CMD_PRE;
            bank_d = seg_ba_d;
            addr_d = ADDR_PRE;
         end
         WAIT_CAS, BURST: begin
            if (cnt_d == seg_c) cmd_d = CMD_BT;
         end
         default: ;
      endcase

      busy_d = (state_d != IDLE);
      end_d  = (state_d == RD_END);
      ack_d  = (state_q == BURST);
      data_d = ack_d ? rd_sdram_data : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         seg_ba_q  <= '0;
         seg_row_q <= '0;
         seg_col_q <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         cmd_q     <= CMD_NOP;
         bank_q    <= '1;
         addr_q    <= '1;
         busy_q    <= 1'b0;
         ack_q     <= 1'b0;
         data_q    <= '0;
         end_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         seg_ba_q  <= seg_ba_d;
         seg_row_q <= seg_row_d;
         seg_col_q <= seg_col_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         cmd_q     <= cmd_d;
         bank_q    <= bank_d;
         addr_q    <= addr_d;
         busy_q    <= busy_d;
         ack_q     <= ack_d;
         data_q    <= data_d;
         end_q     <= end_d;
      end
   end

   assign rd_busy       = busy_q;
   assign rd_cmd        = cmd_q;
   assign rd_bank_addr  = bank_q;
   assign rd_sdram_addr = addr_q;
   assign rd_ack        = ack_q;
   assign rd_data       = data_q;
   assign rd_end        = end_q;

endmodule

// File: tb/tb_sdram_read_ctrl.sv
// Directed bench for sdram_read_ctrl: CL3 and CL2 instances, each fed by a small
// SDRAM behavioural model; command/beat/end events are logged and checked per step.
`timescale 1ns/1ps
module tb_sdram_read_ctrl;
   localparam int DW = 16, BA_W = 2, ROW_W = 13, COL_W = 9, LEN_W = 10;
   localparam int AW = BA_W + ROW_W + COL_W;
   localparam logic [3:0] C_NOP = 4'b1000, C_ACT = 4'b0011, C_RD = 4'b0101;
   localparam logic [3:0] C_BT = 4'b0110, C_PRE = 4'b0010;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic             rd_en3, rd_en2;
   logic [AW-1:0]    rd_addr;
   logic [LEN_W-1:0] rd_len;
   logic [DW-1:0]    dq3, dq2;
   logic             busy3, busy2, ack3, ack2, end3, end2;
   logic [3:0]       cmd3, cmd2;
   logic [BA_W-1:0]  ba3, ba2;
   logic [ROW_W-1:0] a3, a2;
   logic [DW-1:0]    data3, data2;

   sdram_read_ctrl #(.CAS_LAT(3)) u3 (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en3), .rd_addr(rd_addr), .rd_burst_len(rd_len),
      .rd_sdram_data(dq3), .rd_busy(busy3), .rd_cmd(cmd3), .rd_bank_addr(ba3),
      .rd_sdram_addr(a3), .rd_ack(ack3), .rd_data(data3), .rd_end(end3));

   sdram_read_ctrl #(.CAS_LAT(2)) u2 (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en2), .rd_addr(rd_addr), .rd_burst_len(rd_len),
      .rd_sdram_data(dq2), .rd_busy(busy2), .rd_cmd(cmd2), .rd_bank_addr(ba2),
      .rd_sdram_addr(a2), .rd_ack(ack2), .rd_data(data2), .rd_end(end2));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;
   int kacc;

   function automatic logic [DW-1:0] fdat(input logic [AW-1:0] a);
      return DW'(a) ^ DW'(a >> 8) ^ 16'h3C5A;
   endfunction

   // SDRAM model: streams page data from the RD column until BT/PRE, CL cycles late
   typedef struct { int due; logic [DW-1:0] d; } beat_t;
   beat_t q3[$], q2[$];
   logic [ROW_W-1:0] arow3 [4];
   logic [ROW_W-1:0] arow2 [4];
   bit strm3, strm2;
   logic [BA_W-1:0] sba3, sba2;
   logic [COL_W-1:0] scol3, scol2;

   always @(negedge clk) begin
      dq3 = 16'hDEAD;
      if (!rst_n) begin
         strm3 = 1'b0;
         q3.delete();
      end else begin
         while (q3.size() > 0 && q3[0].due <= cyc) begin
            if (q3[0].due == cyc) dq3 = q3[0].d;
            void'(q3.pop_front());
         end
         if (cmd3 == C_ACT) arow3[ba3] = a3;
         if (cmd3 == C_BT || cmd3 == C_PRE) strm3 = 1'b0;
         if (cmd3 == C_RD) begin strm3 = 1'b1; sba3 = ba3; scol3 = a3[COL_W-1:0]; end
         if (strm3) begin
            q3.push_back('{due: cyc + 3, d: fdat({sba3, arow3[sba3], scol3})});
            scol3 = scol3 + COL_W'(1);
         end
      end
   end

   always @(negedge clk) begin
      dq2 = 16'hBEEF;
      if (!rst_n) begin
         strm2 = 1'b0;
         q2.delete();
      end else begin
         while (q2.size() > 0 && q2[0].due <= cyc) begin
            if (q2[0].due == cyc) dq2 = q2[0].d;
            void'(q2.pop_front());
         end
         if (cmd2 == C_ACT) arow2[ba2] = a2;
         if (cmd2 == C_BT || cmd2 == C_PRE) strm2 = 1'b0;
         if (cmd2 == C_RD) begin strm2 = 1'b1; sba2 = ba2; scol2 = a2[COL_W-1:0]; end
         if (strm2) begin
            q2.push_back('{due: cyc + 2, d: fdat({sba2, arow2[sba2], scol2})});
            scol2 = scol2 + COL_W'(1);
         end
      end
   end

   // Event log of the selected instance
   typedef struct { int cyc; logic [3:0] cmd; logic [BA_W-1:0] ba; logic [ROW_W-1:0] a; } ev_t;
   bit sel2 = 1'b0;
   ev_t cmds[$];
   int ackc[$];
   logic [DW-1:0] ackd[$];
   int endc[$];
   int zviol, nbusy;

   logic [3:0] mcmd;
   logic [BA_W-1:0] mba;
   logic [ROW_W-1:0] maddr;
   logic mack, mend, mbusy;
   logic [DW-1:0] mdata;
   assign mcmd  = sel2 ? cmd2 : cmd3;
   assign mba   = sel2 ? ba2 : ba3;
   assign maddr = sel2 ? a2 : a3;
   assign mack  = sel2 ? ack2 : ack3;
   assign mend  = sel2 ? end2 : end3;
   assign mbusy = sel2 ? busy2 : busy3;
   assign mdata = sel2 ? data2 : data3;

   always @(negedge clk) begin
      if (mcmd !== C_NOP) cmds.push_back('{cyc, mcmd, mba, maddr});
      if (mack === 1'b1) begin
         ackc.push_back(cyc);
         ackd.push_back(mdata);
      end else if (mdata !== '0) begin
         zviol++;
      end
      if (mend === 1'b1) endc.push_back(cyc);
      if (mbusy === 1'b1) nbusy++;
   end

   function automatic ev_t ev(input int i);
      ev_t z = '{-1, 4'hF, '0, '0};
      if (i < cmds.size()) z = cmds[i];
      return z;
   endfunction
   function automatic int ac(input int i);
      return (i < ackc.size()) ? ackc[i] : -1;
   endfunction
   function automatic int ec(input int i);
      return (i < endc.size()) ? endc[i] : -1;
   endfunction
   function automatic int data_err(input logic [AW-1:0] s);
      int e = 0;
      for (int i = 0; i < ackd.size(); i++)
         if (ackd[i] !== fdat(s + AW'(i))) e++;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic req(input bit use2, input logic [1:0] ba, input logic [12:0] row,
                      input logic [8:0] col, input int len);
      @(posedge clk); #1;
      sel2 = use2;
      cmds.delete(); ackc.delete(); ackd.delete(); endc.delete();
      zviol = 0; nbusy = 0;
      rd_addr = {ba, row, col};
      rd_len  = LEN_W'(len);
      if (use2) rd_en2 = 1'b1; else rd_en3 = 1'b1;
      kacc = cyc;
      @(posedge clk); #1;
      rd_en2 = 1'b0;
      rd_en3 = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int budget);
      int n = 0;
      while (endc.size() == 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk(tag, 64'(n < budget), 64'd1);
      repeat (8) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, n;
      rd_en3 = 1'b0; rd_en2 = 1'b0; rd_addr = '0; rd_len = '0;
      #22;
      chk("rst_cmd",  64'(cmd3), 64'(C_NOP));
      chk("rst_ba",   64'(ba3), 64'h3);
      chk("rst_addr", 64'(a3), 64'h1FFF);
      chk("rst_flags", 64'({ack3, end3, busy3}), 64'd0);
      chk("rst_data", 64'(data3), 64'd0);
      chk("rst_cmd2", 64'(cmd2), 64'(C_NOP));
      @(negedge clk); rst_n = 1'b1;

      // T1: single 4-beat segment at bank1 row5 col0
      req(1'b0, 2'd1, 13'd5, 9'd0, 4); k = kacc;
      wait_end("t1_done", 100);
      chk("t1_ncmd",   cmds.size(), 4);
      chk("t1_act",    {ev(0).cmd, 2'(ev(0).ba), 13'(ev(0).a)}, {C_ACT, 2'd1, 13'd5});
      chk("t1_act_t",  ev(0).cyc, k + 1);
      chk("t1_rd",     {ev(1).cmd, 2'(ev(1).ba), 13'(ev(1).a)}, {C_RD, 2'd1, 13'd0});
      chk("t1_rd_t",   ev(1).cyc, k + 4);
      chk("t1_bt",     {ev(2).cmd, 2'(ev(2).ba), 13'(ev(2).a)}, {C_BT, 2'd3, 13'h1FFF});
      chk("t1_bt_t",   ev(2).cyc, k + 8);
      chk("t1_pre",    {ev(3).cmd, 2'(ev(3).ba), 13'(ev(3).a)}, {C_PRE, 2'd1, 13'h1BFF});
      chk("t1_pre_t",  ev(3).cyc, k + 11);
      chk("t1_nack",   ackc.size(), 4);
      chk("t1_ack0_t", ac(0), k + 8);
      chk("t1_ack3_t", ac(3), k + 11);
      chk("t1_data",   data_err({2'd1, 13'd5, 9'd0}), 0);
      chk("t1_zero",   zviol, 0);
      chk("t1_nend",   endc.size(), 1);
      chk("t1_end_t",  ec(0), k + 14);
      chk("t1_busy",   nbusy, 14);

      // T2: page crossing at col 510 splits into two segments
      req(1'b0, 2'd2, 13'd100, 9'd510, 4); k = kacc;
      wait_end("t2_done", 100);
      chk("t2_ncmd",   cmds.size(), 8);
      chk("t2_rd1",    {ev(1).cmd, 13'(ev(1).a)}, {C_RD, 13'd510});
      chk("t2_bt1_t",  ev(2).cyc, k + 6);
      chk("t2_pre1_t", ev(3).cyc, k + 9);
      chk("t2_act2",   {ev(4).cmd, 2'(ev(4).ba), 13'(ev(4).a)}, {C_ACT, 2'd2, 13'd101});
      chk("t2_act2_t", ev(4).cyc, k + 12);
      chk("t2_rd2",    {ev(5).cmd, 13'(ev(5).a), 32'(ev(5).cyc)}, {C_RD, 13'd0, 32'(k + 15)});
      chk("t2_pre2_t", ev(7).cyc, k + 20);
      chk("t2_nack",   ackc.size(), 4);
      chk("t2_gap",    {32'(ac(1)), 32'(ac(2))}, {32'(k + 9), 32'(k + 19)});
      chk("t2_data",   data_err({2'd2, 13'd100, 9'd510}), 0);
      chk("t2_end",    {32'(endc.size()), 32'(ec(0))}, {32'd1, 32'(k + 23)});

      // T3: full page in one segment
      req(1'b0, 2'd0, 13'd7, 9'd0, 512); k = kacc;
      wait_end("t3_done", 700);
      chk("t3_ncmd",   cmds.size(), 4);
      chk("t3_bt",     {ev(2).cmd, 32'(ev(2).cyc)}, {C_BT, 32'(k + 516)});
      chk("t3_pre_t",  ev(3).cyc, k + 519);
      chk("t3_nack",   ackc.size(), 512);
      chk("t3_span",   {32'(ac(0)), 32'(ac(511))}, {32'(k + 8), 32'(k + 519)});
      chk("t3_data",   data_err({2'd0, 13'd7, 9'd0}), 0);
      chk("t3_end_t",  ec(0), k + 522);

      // Row overflow carries into the bank
      req(1'b0, 2'd1, 13'd8191, 9'd511, 2); k = kacc;
      wait_end("t3b_done", 100);
      chk("t3b_ncmd",  cmds.size(), 8);
      chk("t3b_act2",  {ev(4).cmd, 2'(ev(4).ba), 13'(ev(4).a)}, {C_ACT, 2'd2, 13'd0});
      chk("t3b_bt1_t", ev(2).cyc, k + 5);
      chk("t3b_data",  {32'(ackc.size()), 32'(data_err({2'd1, 13'd8191, 9'd511}))}, {32'd2, 32'd0});
      chk("t3b_nend",  endc.size(), 1);

      // Top of address space wraps to zero
      req(1'b0, 2'd3, 13'd8191, 9'd511, 2);
      wait_end("t3c_done", 100);
      chk("t3c_act2",  {ev(4).cmd, 2'(ev(4).ba), 13'(ev(4).a)}, {C_ACT, 2'd0, 13'd0});
      chk("t3c_data",  {32'(ackc.size()), 32'(data_err({2'd3, 13'd8191, 9'd511}))}, {32'd2, 32'd0});

      // T4: zero-length request
      req(1'b0, 2'd1, 13'd2, 9'd3, 0); k = kacc;
      wait_end("t4_done", 20);
      chk("t4_ncmd",   cmds.size(), 0);
      chk("t4_nack",   ackc.size(), 0);
      chk("t4_end",    {32'(endc.size()), 32'(ec(0))}, {32'd1, 32'(k + 1)});
      chk("t4_busy",   nbusy, 1);

      // rd_en while busy is ignored
      req(1'b0, 2'd0, 13'd9, 9'd20, 4);
      for (int i = 0; i < 5; i++) begin
         rd_addr = {2'd3, 13'd50, 9'd0};
         rd_len  = LEN_W'(9);
         rd_en3  = 1'b1;
         @(posedge clk); #1;
      end
      rd_en3 = 1'b0;
      wait_end("t4b_done", 100);
      chk("t4b_ncmd",  cmds.size(), 4);
      chk("t4b_act",   13'(ev(0).a), 13'd9);
      chk("t4b_nack",  ackc.size(), 4);
      chk("t4b_data",  data_err({2'd0, 13'd9, 9'd20}), 0);
      chk("t4b_nend",  endc.size(), 1);

      // T5: CAS latency 2 instance
      req(1'b1, 2'd0, 13'd3, 9'd10, 3); k = kacc;
      wait_end("t5_done", 100);
      chk("t5_ncmd",   cmds.size(), 4);
      chk("t5_rd_t",   {ev(1).cmd, 32'(ev(1).cyc)}, {C_RD, 32'(k + 4)});
      chk("t5_bt_t",   {ev(2).cmd, 32'(ev(2).cyc)}, {C_BT, 32'(k + 7)});
      chk("t5_pre_t",  {ev(3).cmd, 32'(ev(3).cyc)}, {C_PRE, 32'(k + 9)});
      chk("t5_ack",    {32'(ackc.size()), 32'(ac(0)), 32'(ac(2))}, {32'd3, 32'(k + 7), 32'(k + 9)});
      chk("t5_data",   data_err({2'd0, 13'd3, 9'd10}), 0);
      chk("t5_end_t",  ec(0), k + 12);

      // T6: reset in the middle of a burst
      req(1'b0, 2'd1, 13'd40, 9'd0, 8);
      n = 0;
      while (ack3 !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("t6_in_burst", 64'(ack3), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("t6_cmd",    64'(cmd3), 64'(C_NOP));
      chk("t6_flags",  64'({ack3, busy3}), 64'd0);
      @(posedge clk); #1;
      chk("t6_hold",   64'({cmd3, ack3, busy3, end3}), 64'({C_NOP, 3'b000}));
      @(negedge clk); rst_n = 1'b1;
      chk("t6_noend",  endc.size(), 0);
      req(1'b0, 2'd1, 13'd41, 9'd5, 4);
      wait_end("t6b_done", 100);
      chk("t6b_nack",  ackc.size(), 4);
      chk("t6b_data",  data_err({2'd1, 13'd41, 9'd5}), 0);
      chk("t6b_nend",  {32'(endc.size()), 32'(cmds.size())}, {32'd1, 32'd4});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
